pzvip_stream_rr_arbiter: RTL

PZVIP_STREAM_RR_ARBITER -- requirements
Module: pzvip_stream_rr_arbiter

---
 rtl/pzvip_stream_rr_arbiter_pkg.sv | 20 ++
 rtl/pzvip_stream_rr_select.sv | 39 +++
 rtl/pzvip_stream_rr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pzvip_stream_rr_arbiter_pkg.sv
// rtl/pzvip_stream_rr_arbiter_pkg.sv - shared types and helpers for the stream round-robin arbiter
package pzvip_stream_rr_arbiter_pkg;

    // Arbiter FSM: IDLE arbitrates combinationally, LOCKED holds one requester
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Width needed to index n requesters (n >= 2 always yields at least 1)
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/pzvip_stream_rr_select.sv
// rtl/pzvip_stream_rr_select.sv - rotating-priority search starting at ptr
module pzvip_stream_rr_select
    import pzvip_stream_rr_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             found_o
);

    // One extra bit so ptr+offset never overflows before the explicit wrap
    logic [PTR_W:0] cand;

    // Walk ptr, ptr+1, ... wrapping at N; the first requester found wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int off = 0; off < N; off++) begin
            cand = {1'b0, ptr_i} + (PTR_W+1)'(off);
            if (cand >= (PTR_W+1)'(N)) begin
                cand = cand - (PTR_W+1)'(N);
            end
            if (!found_o && req_i[cand[PTR_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[PTR_W-1:0];
            end
        end
        if (found_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/pzvip_stream_rr_arbiter.sv
// rtl/pzvip_stream_rr_arbiter.sv - packet-locked round-robin arbiter for N valid/ready streams
module pzvip_stream_rr_arbiter
    import pzvip_stream_rr_arbiter_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N-1:0]              i_valid,
    output logic [N-1:0]              o_ready,
    input  logic [N*DATA_WIDTH-1:0]   i_data,
    input  logic [N*DATA_WIDTH/8-1:0] i_byte_enable,
    input  logic [N-1:0]              i_last,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic [DATA_WIDTH/8-1:0]   o_byte_enable,
    output logic                      o_last,
    output logic [N-1:0]              o_grant,
    output logic                      o_busy
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = clog2(N);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] lock_q, lock_d;

    logic [N-1:0]     sel_grant;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_found;

    logic [N-1:0]     grant;
    logic [PTR_W-1:0] cur_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             ack;

    pzvip_stream_rr_select #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_select (
        .req_i   (i_valid),
        .ptr_i   (ptr_q),
        .grant_o (sel_grant),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    // Current grant: live search in IDLE, frozen requester in LOCKED, nothing in reset
    always_comb begin
        grant   = '0;
        cur_idx = sel_idx;
        if (state_q == ST_LOCKED) begin
            cur_idx        = lock_q;
            grant[lock_q]  = 1'b1;
        end else if (sel_found) begin
            grant = sel_grant;
        end
        if (!i_rst_n) begin
            grant = '0;
        end
    end

    // AND-OR payload mux on the one-hot grant; zero grant yields zero payload
    always_comb begin
        o_valid       = 1'b0;
        o_last        = 1'b0;
        o_data        = '0;
        o_byte_enable = '0;
        for (int k = 0; k < N; k++) begin
            o_valid       = o_valid | (grant[k] & i_valid[k]);
            o_last        = o_last  | (grant[k] & i_last[k]);
            o_data        = o_data  | ({DATA_WIDTH{grant[k]}} & i_data[k*DATA_WIDTH +: DATA_WIDTH]);
            o_byte_enable = o_byte_enable | ({BE_W{grant[k]}} & i_byte_enable[k*BE_W +: BE_W]);
        end
    end

    assign o_ready  = grant & {N{i_ready}};
    assign o_grant  = grant;
    assign o_busy   = (state_q == ST_LOCKED) && i_rst_n;
    assign ack      = o_valid && i_ready;
    assign next_ptr = (cur_idx == LAST_IDX) ? '0 : cur_idx + PTR_W'(1);

    // Next state: lock on any pending or partial packet, rotate ptr past the last beat's owner
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        case (state_q)
            ST_IDLE: begin
                if (o_valid) begin
                    if (ack && o_last) begin
                        ptr_d = next_ptr;
                    end else begin
                        state_d = ST_LOCKED;
                        lock_d  = sel_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (ack && o_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any partial packet and restarts at requester 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

endmodule
